// File: rtl/mc6502_decode_issue.sv
// mc6502_decode_issue: fetch/decode/issue stage of the MC6502 core.
// Fetches opcode and operand bytes from the memory controller, resolves
// zero-page/absolute operand reads, and issues one-cycle command strobes to
// the execution controller, then sequences on ec2id_done with a watchdog.
// Ports:
//   clk, rst_x            clock, asynchronous active-low reset
//   mc2id_data/valid      byte returned by the memory controller
//   id2mc_fetch/read/addr byte requests (fetch at PC, read at id2mc_addr)
//   rf2id_a/x/y/s         register file values
//   id2ec_*               flag/load/ops/branch strobes plus opcode/data/reg
//   ec2id_done            execution complete
//   id2x_illegal          one-cycle pulse: unsupported opcode or watchdog abort
// All outputs are flops loaded from the next-state decode, so reset forces
// every output to 0 and each strobe lasts exactly one cycle.
module mc6502_decode_issue #(
    parameter int unsigned WAIT_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_x,
    input  logic [7:0]  mc2id_data,
    input  logic        mc2id_valid,
    output logic        id2mc_fetch,
    output logic        id2mc_read,
    output logic [15:0] id2mc_addr,
    input  logic [7:0]  rf2id_a,
    input  logic [7:0]  rf2id_x,
    input  logic [7:0]  rf2id_y,
    input  logic [7:0]  rf2id_s,
    output logic        id2ec_reset_c,
    output logic        id2ec_set_c,
    output logic        id2ec_reset_i,
    output logic        id2ec_set_i,
    output logic        id2ec_reset_v,
    output logic        id2ec_reset_d,
    output logic        id2ec_set_d,
    output logic        id2ec_load,
    output logic        id2ec_ops,
    output logic        id2ec_branch,
    output logic [4:0]  id2ec_opcode,
    output logic [7:0]  id2ec_data,
    output logic [1:0]  id2ec_reg,
    input  logic        ec2id_done,
    output logic        id2x_illegal
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic [2:0] {
        S_FETCH_OP, S_FETCH_LO, S_FETCH_HI, S_READ, S_ISSUE, S_WAIT
    } state_e;

    // addressing mode, with NOP and illegal folded in as pseudo-modes
    localparam logic [2:0] M_IMP = 3'd0, M_IMM = 3'd1, M_REL = 3'd2, M_ZP = 3'd3,
                           M_ABS = 3'd4, M_NOP = 3'd5, M_ILL = 3'd6;
    localparam logic [1:0] D_HOLD = 2'd0, D_BUS = 2'd1, D_REG = 2'd2;
    localparam logic [1:0] R_A = 2'd0, R_X = 2'd1, R_Y = 2'd2, R_S = 2'd3;

    typedef struct packed {
        logic [2:0] mode;
        logic [6:0] flags;     // {set_d, reset_d, reset_v, set_i, reset_i, set_c, reset_c}
        logic       load;
        logic       ops;
        logic       branch;
        logic       upd;       // update opcode/reg (flag ops leave them untouched)
        logic [4:0] opc;
        logic [1:0] rsel;
        logic [1:0] dsrc;
        logic [1:0] src;
    } dec_t;

    function automatic logic [2:0] mode_of(input logic [2:0] bbb);
        case (bbb)
            3'b010:  mode_of = M_IMM;
            3'b001:  mode_of = M_ZP;
            default: mode_of = M_ABS;
        endcase
    endfunction

    function automatic dec_t decode(input logic [7:0] b);
        dec_t       d;
        logic [2:0] aaa;
        logic [2:0] bbb;
        logic [1:0] cc;
        logic       mem_mode;
        aaa      = b[7:5];
        bbb      = b[4:2];
        cc       = b[1:0];
        mem_mode = (bbb == 3'b001) || (bbb == 3'b011);
        d        = '0;
        d.mode   = M_ILL;
        d.upd    = 1'b1;
        d.opc    = {cc, aaa};
        case (b)
            8'hEA: d.mode = M_NOP;
            8'hE8, 8'hC8, 8'hCA, 8'h88: begin
                d.mode = M_IMP;
                d.ops  = 1'b1;
                d.load = 1'b1;
                d.dsrc = D_REG;
                d.opc  = (b == 8'hE8 || b == 8'hC8) ? 5'b10111 : 5'b10110;
                d.rsel = (b == 8'hE8 || b == 8'hCA) ? R_X : R_Y;
                d.src  = d.rsel;
            end
            8'hAA, 8'hA8, 8'h8A, 8'h98, 8'h9A, 8'hBA: begin
                d.mode = M_IMP;
                d.load = 1'b1;
                d.dsrc = D_REG;
                case (b)
                    8'hAA:   begin d.rsel = R_X; d.src = R_A; end
                    8'hA8:   begin d.rsel = R_Y; d.src = R_A; end
                    8'h8A:   begin d.rsel = R_A; d.src = R_X; end
                    8'h98:   begin d.rsel = R_A; d.src = R_Y; end
                    8'h9A:   begin d.rsel = R_S; d.src = R_X; end
                    default: begin d.rsel = R_X; d.src = R_S; end
                endcase
            end
            8'h18, 8'h38, 8'h58, 8'h78, 8'hB8, 8'hD8, 8'hF8: begin
                d.mode = M_IMP;
                d.upd  = 1'b0;
                case (aaa)
                    3'b000:  d.flags = 7'b0000001;
                    3'b001:  d.flags = 7'b0000010;
                    3'b010:  d.flags = 7'b0000100;
                    3'b011:  d.flags = 7'b0001000;
                    3'b101:  d.flags = 7'b0010000;
                    3'b110:  d.flags = 7'b0100000;
                    default: d.flags = 7'b1000000;
                endcase
            end
            default: begin
                if (b[4:0] == 5'b10000) begin
                    d.mode   = M_REL;
                    d.branch = 1'b1;
                    d.opc    = {2'b00, aaa};
                    d.dsrc   = D_BUS;
                end else if (cc == 2'b01 && (bbb == 3'b010 || mem_mode)) begin
                    d.mode = mode_of(bbb);
                    d.dsrc = D_BUS;
                    if (aaa == 3'b101) begin
                        d.load = 1'b1;
                    end else if (aaa == 3'b100) begin
                        d.mode = M_ILL;
                    end else begin
                        d.ops = 1'b1;
                    end
                end else if (cc == 2'b10 && !aaa[2] && bbb == 3'b010) begin
                    d.mode = M_IMP;
                    d.ops  = 1'b1;
                    d.load = 1'b1;
                    d.dsrc = D_REG;
                end else if (cc == 2'b10 && (!aaa[2] || aaa[2:1] == 2'b11) && mem_mode) begin
                    d.mode = mode_of(bbb);
                    d.ops  = 1'b1;
                    d.dsrc = D_BUS;
                end
            end
        endcase
        return d;
    endfunction

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    dec_t               dec_q, dec_d;
    logic [7:0]         lo_q, lo_d;
    logic               abort;
    logic               fetch_q, fetch_d, read_q, read_d, illegal_q, illegal_d;
    logic               load_q, load_d, ops_q, ops_d, branch_q, branch_d;
    logic [6:0]         flags_q, flags_d;
    logic [15:0]        addr_q, addr_d;
    logic [4:0]         opcode_q, opcode_d;
    logic [7:0]         data_q, data_d;
    logic [1:0]         reg_q, reg_d;
    logic               fetch_ack, read_ack;

    assign fetch_ack = fetch_q & mc2id_valid;
    assign read_ack  = read_q & mc2id_valid;

    // state and output registers
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            state_q   <= S_FETCH_OP;
            cnt_q     <= '0;
            dec_q     <= '0;
            lo_q      <= '0;
            fetch_q   <= 1'b0;
            read_q    <= 1'b0;
            illegal_q <= 1'b0;
            load_q    <= 1'b0;
            ops_q     <= 1'b0;
            branch_q  <= 1'b0;
            flags_q   <= '0;
            addr_q    <= '0;
            opcode_q  <= '0;
            data_q    <= '0;
            reg_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dec_q     <= dec_d;
            lo_q      <= lo_d;
            fetch_q   <= fetch_d;
            read_q    <= read_d;
            illegal_q <= illegal_d;
            load_q    <= load_d;
            ops_q     <= ops_d;
            branch_q  <= branch_d;
            flags_q   <= flags_d;
            addr_q    <= addr_d;
            opcode_q  <= opcode_d;
            data_q    <= data_d;
            reg_q     <= reg_d;
        end
    end

    // next-state logic; done is only looked at in S_ISSUE/S_WAIT
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dec_d   = dec_q;
        lo_d    = lo_q;
        abort   = 1'b0;
        case (state_q)
            S_FETCH_OP: if (fetch_ack) begin
                dec_d = decode(mc2id_data);
                case (dec_d.mode)
                    M_NOP:   state_d = S_FETCH_OP;
                    M_ILL:   begin state_d = S_FETCH_OP; abort = 1'b1; end
                    M_IMP:   state_d = S_ISSUE;
                    default: state_d = S_FETCH_LO;
                endcase
            end
            S_FETCH_LO: if (fetch_ack) begin
                lo_d = mc2id_data;
                case (dec_q.mode)
                    M_ZP:    state_d = S_READ;
                    M_ABS:   state_d = S_FETCH_HI;
                    default: state_d = S_ISSUE;
                endcase
            end
            S_FETCH_HI: if (fetch_ack) state_d = S_READ;
            S_READ:     if (read_ack)  state_d = S_ISSUE;
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = ec2id_done ? S_FETCH_OP : S_WAIT;
            end
            S_WAIT: begin
                if (ec2id_done) begin
                    state_d = S_FETCH_OP;
                    cnt_d   = '0;
                end else if (32'(cnt_q) + 32'd1 >= WAIT_LIMIT) begin
                    // watchdog: execution controller never answered
                    state_d = S_FETCH_OP;
                    abort   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_FETCH_OP;
        endcase
    end

    // output logic, registered against the state being entered
    always_comb begin
        fetch_d   = (state_d == S_FETCH_OP) || (state_d == S_FETCH_LO) || (state_d == S_FETCH_HI);
        read_d    = (state_d == S_READ);
        illegal_d = abort;
        flags_d   = '0;
        load_d    = 1'b0;
        ops_d     = 1'b0;
        branch_d  = 1'b0;
        addr_d    = addr_q;
        opcode_d  = opcode_q;
        data_d    = data_q;
        reg_d     = reg_q;
        if (state_q == S_FETCH_LO && fetch_ack && dec_q.mode == M_ZP) begin
            addr_d = {8'h00, mc2id_data};
        end
        if (state_q == S_FETCH_HI && fetch_ack) begin
            addr_d = {mc2id_data, lo_q};
        end
        if (state_d == S_ISSUE) begin
            flags_d  = dec_d.flags;
            load_d   = dec_d.load;
            ops_d    = dec_d.ops;
            branch_d = dec_d.branch;
            if (dec_d.upd) begin
                opcode_d = dec_d.opc;
                reg_d    = dec_d.rsel;
            end
            case (dec_d.dsrc)
                D_BUS: data_d = mc2id_data;
                D_REG: begin
                    case (dec_d.src)
                        R_A:     data_d = rf2id_a;
                        R_X:     data_d = rf2id_x;
                        R_Y:     data_d = rf2id_y;
                        default: data_d = rf2id_s;
                    endcase
                end
                default: data_d = data_q;
            endcase
        end
    end

    assign id2mc_fetch   = fetch_q;
    assign id2mc_read    = read_q;
    assign id2mc_addr    = addr_q;
    assign id2ec_reset_c = flags_q[0];
    assign id2ec_set_c   = flags_q[1];
    assign id2ec_reset_i = flags_q[2];
    assign id2ec_set_i   = flags_q[3];
    assign id2ec_reset_v = flags_q[4];
    assign id2ec_reset_d = flags_q[5];
    assign id2ec_set_d   = flags_q[6];
    assign id2ec_load    = load_q;
    assign id2ec_ops     = ops_q;
    assign id2ec_branch  = branch_q;
    assign id2ec_opcode  = opcode_q;
    assign id2ec_data    = data_q;
    assign id2ec_reg     = reg_q;
    assign id2x_illegal  = illegal_q;

endmodule

// File: tb/tb_mc6502_decode_issue.sv
// Directed bench for mc6502_decode_issue: a zero-latency memory responder
// serves fetch/read requests at each falling edge, and the script checks
// outputs cycle by cycle against hand-computed values.
module tb_mc6502_decode_issue;

    logic        clk = 1'b0;
    logic        rst_x;
    logic [7:0]  mc2id_data;
    logic        mc2id_valid;
    logic        id2mc_fetch, id2mc_read;
    logic [15:0] id2mc_addr;
    logic [7:0]  rf2id_a, rf2id_x, rf2id_y, rf2id_s;
    logic        id2ec_reset_c, id2ec_set_c, id2ec_reset_i, id2ec_set_i;
    logic        id2ec_reset_v, id2ec_reset_d, id2ec_set_d;
    logic        id2ec_load, id2ec_ops, id2ec_branch;
    logic [4:0]  id2ec_opcode;
    logic [7:0]  id2ec_data;
    logic [1:0]  id2ec_reg;
    logic        ec2id_done;
    logic        id2x_illegal;

    logic [7:0]  mem [0:65535];
    logic [15:0] pc;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    mc6502_decode_issue #(.WAIT_LIMIT(4)) dut (
        .clk(clk), .rst_x(rst_x),
        .mc2id_data(mc2id_data), .mc2id_valid(mc2id_valid),
        .id2mc_fetch(id2mc_fetch), .id2mc_read(id2mc_read), .id2mc_addr(id2mc_addr),
        .rf2id_a(rf2id_a), .rf2id_x(rf2id_x), .rf2id_y(rf2id_y), .rf2id_s(rf2id_s),
        .id2ec_reset_c(id2ec_reset_c), .id2ec_set_c(id2ec_set_c),
        .id2ec_reset_i(id2ec_reset_i), .id2ec_set_i(id2ec_set_i),
        .id2ec_reset_v(id2ec_reset_v), .id2ec_reset_d(id2ec_reset_d),
        .id2ec_set_d(id2ec_set_d), .id2ec_load(id2ec_load), .id2ec_ops(id2ec_ops),
        .id2ec_branch(id2ec_branch), .id2ec_opcode(id2ec_opcode),
        .id2ec_data(id2ec_data), .id2ec_reg(id2ec_reg),
        .ec2id_done(ec2id_done), .id2x_illegal(id2x_illegal)
    );

    // {reset_c, set_c, reset_i, set_i, reset_v, reset_d, set_d, load, ops, branch}
    function automatic logic [31:0] strobes();
        return 32'({id2ec_reset_c, id2ec_set_c, id2ec_reset_i, id2ec_set_i, id2ec_reset_v,
                    id2ec_reset_d, id2ec_set_d, id2ec_load, id2ec_ops, id2ec_branch});
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // advance one cycle to the next falling edge and answer any pending request
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        mc2id_valid = 1'b0;
        if (id2mc_fetch) begin
            mc2id_data  = mem[pc];
            pc          = pc + 16'd1;
            mc2id_valid = 1'b1;
        end else if (id2mc_read) begin
            mc2id_data  = mem[id2mc_addr];
            mc2id_valid = 1'b1;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_fetch"},   32'(id2mc_fetch),  'h0);
        check_val({tag, "_read"},    32'(id2mc_read),   'h0);
        check_val({tag, "_addr"},    32'(id2mc_addr),   'h0);
        check_val({tag, "_strobes"}, strobes(),         'h0);
        check_val({tag, "_illegal"}, 32'(id2x_illegal), 'h0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
        // LDA #$42; SEC; INC $10; BNE -16; BNE +5; illegal 02; INC $10
        mem[0]  = 8'hA9; mem[1]  = 8'h42; mem[2]  = 8'h38;
        mem[3]  = 8'hE6; mem[4]  = 8'h10;
        mem[5]  = 8'hD0; mem[6]  = 8'hF0; mem[7]  = 8'hD0; mem[8]  = 8'h05;
        mem[9]  = 8'h02; mem[10] = 8'hE6; mem[11] = 8'h10;
        mem[16'h0010] = 8'h7F;
        rf2id_a = 8'h11; rf2id_x = 8'h22; rf2id_y = 8'h33; rf2id_s = 8'h44;
        mc2id_data = 8'h00; mc2id_valid = 1'b0; ec2id_done = 1'b0; pc = 16'd0;

        rst_x = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        check_val("reset_opcode", 32'(id2ec_opcode), 'h0);
        check_val("reset_data",   32'(id2ec_data),   'h0);
        check_val("reset_reg",    32'(id2ec_reg),    'h0);
        rst_x = 1'b1;

        // LDA #$42: done in the issue cycle, fetch resumes next cycle
        tick();
        check_val("lda_fetch_req", 32'(id2mc_fetch), 'h1);
        tick();
        tick();
        check_val("lda_strobes", strobes(),            'h004);
        check_val("lda_data",    32'(id2ec_data),      'h42);
        check_val("lda_reg",     32'(id2ec_reg),       'h0);
        check_val("lda_opcode",  32'(id2ec_opcode),    'h0D);
        ec2id_done = 1'b1;
        tick();
        ec2id_done = 1'b0;
        check_val("lda_strobe_drop", strobes(),         'h0);
        check_val("lda_next_fetch",  32'(id2mc_fetch),  'h1);

        // SEC: one-cycle set_c, done one cycle later, opcode untouched
        tick();
        check_val("sec_strobes", strobes(),            'h100);
        check_val("sec_opcode",  32'(id2ec_opcode),    'h0D);
        tick();
        check_val("sec_strobe_drop", strobes(),        'h0);
        check_val("sec_wait_fetch",  32'(id2mc_fetch), 'h0);
        ec2id_done = 1'b1;
        tick();
        ec2id_done = 1'b0;
        check_val("sec_next_fetch", 32'(id2mc_fetch), 'h1);

        // INC $10 with mem[0010]=7F; a stray done during the read is ignored
        tick();
        tick();
        check_val("inc_read",      32'(id2mc_read), 'h1);
        check_val("inc_read_addr", 32'(id2mc_addr), 'h0010);
        ec2id_done = 1'b1;
        tick();
        ec2id_done = 1'b0;
        check_val("inc_strobes", strobes(),         'h002);
        check_val("inc_opcode",  32'(id2ec_opcode), 'h17);
        check_val("inc_data",    32'(id2ec_data),   'h7F);
        check_val("inc_addr",    32'(id2mc_addr),   'h0010);
        tick();
        check_val("inc_strobe_drop", strobes(),         'h0);
        check_val("inc_addr_hold1",  32'(id2mc_addr),   'h0010);
        tick();
        check_val("inc_still_wait",  32'(id2mc_fetch),  'h0);
        check_val("inc_addr_hold2",  32'(id2mc_addr),   'h0010);
        check_val("inc_data_hold",   32'(id2ec_data),   'h7F);
        ec2id_done = 1'b1;
        tick();
        ec2id_done = 1'b0;
        check_val("inc_next_fetch", 32'(id2mc_fetch), 'h1);

        // BNE -16 with page cross: done one cycle after issue
        tick();
        tick();
        check_val("bne_x_strobes", strobes(),         'h001);
        check_val("bne_x_data",    32'(id2ec_data),   'hF0);
        check_val("bne_x_opcode",  32'(id2ec_opcode), 'h06);
        tick();
        check_val("bne_x_drop",    strobes(),         'h0);
        check_val("bne_x_wait",    32'(id2mc_fetch),  'h0);
        ec2id_done = 1'b1;
        tick();
        ec2id_done = 1'b0;
        check_val("bne_x_next_fetch", 32'(id2mc_fetch), 'h1);

        // BNE +5 without page cross: done in the issue cycle
        tick();
        tick();
        check_val("bne_strobes", strobes(),       'h001);
        check_val("bne_data",    32'(id2ec_data), 'h05);
        ec2id_done = 1'b1;
        tick();
        ec2id_done = 1'b0;
        check_val("bne_drop",       strobes(),         'h0);
        check_val("bne_next_fetch", 32'(id2mc_fetch),  'h1);

        // illegal 02: pulse, no strobes, fetch continues
        tick();
        check_val("ill_pulse",   32'(id2x_illegal), 'h1);
        check_val("ill_strobes", strobes(),         'h0);
        check_val("ill_fetch",   32'(id2mc_fetch),  'h1);
        tick();
        check_val("ill_pulse_end", 32'(id2x_illegal), 'h0);

        // INC $10 with done never returning: watchdog after 4 wait cycles
        tick();
        tick();
        check_val("wdog_issue", strobes(), 'h002);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("wdog_waiting", 32'(id2x_illegal), 'h0);
            check_val("wdog_no_fetch", 32'(id2mc_fetch), 'h0);
        end
        tick();
        check_val("wdog_abort",  32'(id2x_illegal), 'h1);
        check_val("wdog_fetch",  32'(id2mc_fetch),  'h1);
        tick();
        check_val("wdog_abort_end", 32'(id2x_illegal), 'h0);

        // reset in the middle of LDA $1234 (during the high-byte fetch)
        mem[0] = 8'hAD; mem[1] = 8'h34; mem[2] = 8'h12; mem[16'h1234] = 8'h5A;
        rst_x = 1'b0;
        mc2id_valid = 1'b0;
        pc = 16'd0;
        @(negedge clk);
        rst_x = 1'b1;
        tick();
        tick();
        tick();
        check_val("rst_fetch_hi", 32'(id2mc_fetch), 'h1);
        rst_x = 1'b0;
        #1;
        check_idle_outputs("rst_mid");
        mc2id_valid = 1'b0;
        pc = 16'd0;
        @(negedge clk);
        check_val("rst_held_fetch", 32'(id2mc_fetch), 'h0);
        rst_x = 1'b1;
        tick();
        check_val("rst_refetch", 32'(id2mc_fetch), 'h1);
        tick();
        tick();
        tick();
        check_val("abs_read",      32'(id2mc_read), 'h1);
        check_val("abs_read_addr", 32'(id2mc_addr), 'h1234);
        tick();
        check_val("abs_strobes", strobes(),       'h004);
        check_val("abs_data",    32'(id2ec_data), 'h5A);
        check_val("abs_reg",     32'(id2ec_reg),  'h0);
        ec2id_done = 1'b1;
        tick();
        ec2id_done = 1'b0;
        check_val("abs_next_fetch", 32'(id2mc_fetch), 'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
